// File: rtl/spi_cmd_queue.sv
// Command scheduler for the 4-slave spi core: FIFO of {slave, byte} commands, one byte window each.
// Latency: accept-to-rsp_valid is XFER_CYCLES+1 edges; back-to-back windows every XFER_CYCLES+2 cycles.
// Backpressure: cmd_ready drops when the FIFO is full; a held response (rsp_ready=0) stalls new windows.
// Optional: define SPI_CMDQ_DROP_CNT_EN to add the drop_cnt port counting refused offer cycles.
module spi_cmd_queue #(
  parameter int DEPTH       = 4,
  parameter int XFER_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_slave,
  input  logic [7:0] cmd_data,
  output logic [3:0] spi_select,
  output logic [7:0] spi_data_out,
  input  logic [7:0] spi_data_in,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_slave,
  output logic       busy
`ifdef SPI_CMDQ_DROP_CNT_EN
  ,
  output logic [7:0] drop_cnt
`endif
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = $clog2(XFER_CYCLES + 1);
  localparam logic [CntW-1:0] LastBit  = CntW'(XFER_CYCLES - 1);
  localparam logic [PtrW:0]   FullCnt  = (PtrW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, XFER, GAP} stateT;

  stateT           state;
  stateT           nextState;
  logic [1:0]      fifoSlave [DEPTH];
  logic [7:0]      fifoData  [DEPTH];
  logic [PtrW-1:0] wrPtr;
  logic [PtrW-1:0] rdPtr;
  logic [PtrW:0]   count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [CntW-1:0] bitCnt;
  logic            lastBit;
  logic [1:0]      curSlave;

  assign full      = (count == FullCnt);
  assign empty     = (count == '0);
  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign lastBit   = (bitCnt == LastBit);
  assign busy      = (state != IDLE);

  // Command storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoSlave[wrPtr] <= cmd_slave;
      fifoData[wrPtr]  <= cmd_data;
    end
  end

  // FIFO pointers and occupancy; push and pop together leave occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Scheduler state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next state and pop; a held response blocks the next window so it is never overwritten.
  always_comb begin
    nextState = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !rsp_valid) begin
          pop       = 1'b1;
          nextState = XFER;
        end
      end
      XFER: begin
        if (lastBit) nextState = GAP;
      end
      GAP:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Registered select/data towards the core and the single-entry response slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      bitCnt       <= '0;
      curSlave     <= '0;
      spi_select   <= '0;
      spi_data_out <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_slave    <= '0;
    end else begin
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            curSlave     <= fifoSlave[rdPtr];
            spi_data_out <= fifoData[rdPtr];
            spi_select   <= 4'b0001 << fifoSlave[rdPtr];
            bitCnt       <= '0;
          end
        end
        XFER: begin
          bitCnt <= bitCnt + 1'b1;
          if (lastBit) begin
            spi_select <= '0;
            rsp_data   <= spi_data_in;
            rsp_slave  <= curSlave;
            rsp_valid  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_CMDQ_DROP_CNT_EN
  // Saturating count of cycles where a command was offered into a full FIFO.
  always_ff @(posedge clk) begin
    if (rst)                                         drop_cnt <= '0;
    else if (cmd_valid && full && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_spi_cmd_queue.sv
// Scoreboard bench for spi_cmd_queue: directed commands, expected windows/responses queued at acceptance.
module tb_spi_cmd_queue;
  localparam int XFER = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_slave;
  logic [7:0] cmd_data;
  logic [3:0] spi_select;
  logic [7:0] spi_data_out;
  logic [7:0] spi_data_in;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_slave;
  logic       busy;
`ifdef SPI_CMDQ_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  spi_cmd_queue #(.DEPTH(4), .XFER_CYCLES(XFER)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_slave(cmd_slave), .cmd_data(cmd_data),
    .spi_select(spi_select), .spi_data_out(spi_data_out), .spi_data_in(spi_data_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_slave(rsp_slave),
    .busy(busy)
`ifdef SPI_CMDQ_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  logic [9:0]  expRsp [$];   // {slave, byte returned by core}
  logic [11:0] expWin [$];   // {master byte, one-hot select}

  // Core model: returns the inverted master byte only in the last cycle of a window.
  int winCnt = 0;
  always @(posedge clk) winCnt <= (spi_select != 4'b0) ? winCnt + 1 : 0;
  assign spi_data_in = (spi_select != 4'b0 && winCnt == XFER - 1) ? ~spi_data_out : 8'h5A;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Response monitor.
  logic [9:0] rspE;
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (expRsp.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected: got slave %0d data %0h, expected no response", rsp_slave, rsp_data);
      end else begin
        rspE = expRsp.pop_front();
        check("rsp_data", {24'b0, rsp_data}, {24'b0, rspE[7:0]});
        check("rsp_slave", {30'b0, rsp_slave}, {30'b0, rspE[9:8]});
      end
    end
  end

  // Window monitor: select value, data stability, window length and inter-window gap.
  logic        inWin = 1'b0;
  int          winLen = 0;
  int          lowCnt = 0;
  logic [11:0] winE;
  logic        gapArm = 1'b0;
  logic        gapPrev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      inWin  = 1'b0;
      lowCnt = 0;
    end else if (spi_select != 4'b0) begin
      if (!inWin) begin
        inWin  = 1'b1;
        winLen = 1;
        if (gapArm && gapPrev) check("gap_len", lowCnt, 2);
        gapPrev = gapArm;
        if (expWin.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL win_unexpected: got select %b data %0h, expected idle", spi_select, spi_data_out);
          winE = {spi_data_out, spi_select};
        end else begin
          winE = expWin.pop_front();
          check("sel_onehot", {28'b0, spi_select}, {28'b0, winE[3:0]});
          check("data_out", {24'b0, spi_data_out}, {24'b0, winE[11:4]});
        end
      end else begin
        winLen++;
        check("sel_hold", {28'b0, spi_select}, {28'b0, winE[3:0]});
        check("data_hold", {24'b0, spi_data_out}, {24'b0, winE[11:4]});
      end
    end else begin
      if (inWin) begin
        check("win_len", winLen, XFER);
        inWin  = 1'b0;
        lowCnt = 0;
      end
      lowCnt++;
    end
  end

  // Offer one command until accepted (bounded); expectations are queued on acceptance.
  task automatic push(input logic [1:0] s, input logic [7:0] d);
    int n;
    logic [3:0] sel;
    n = 0;
    sel = 4'b0001 << s;
    cmd_valid = 1'b1;
    cmd_slave = s;
    cmd_data  = d;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("push_accept", {31'b0, cmd_ready}, 32'd1);
    if (cmd_ready) begin
      expRsp.push_back({s, ~d});
      expWin.push_back({d, sel});
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expRsp.size() != 0 || expWin.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_rsp_left", expRsp.size(), 0);
  endtask

  int n;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_slave = '0; cmd_data = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("rst_select", {28'b0, spi_select}, 32'd0);
    check("rst_data_out", {24'b0, spi_data_out}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'b0, rsp_data}, 32'd0);
    check("rst_rsp_slave", {30'b0, rsp_slave}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
`ifdef SPI_CMDQ_DROP_CNT_EN
    check("rst_drop_cnt", {24'b0, drop_cnt}, 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_rst", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk); #1;

    // Reset in the middle of a slave-2 window: nothing may come back.
    push(2'd2, 8'h3C);
    repeat (4) @(posedge clk);
    #1;
    check("busy_mid_xfer", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    expRsp.delete();
    expWin.delete();
    @(posedge clk); #1;
    check("midrst_select", {28'b0, spi_select}, 32'd0);
    check("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("midrst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_cmd_ready_rel", {31'b0, cmd_ready}, 32'd1);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    repeat (20) @(posedge clk);
    #1;

    // Single command, slave index 1, byte 0xF0; core returns 0x0F; latency 9 edges.
    rsp_ready = 1'b0;
    push(2'd1, 8'hF0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 4) check("busy_single", {31'b0, busy}, 32'd1);
    end while (!rsp_valid && n < 30);
    check("latency", n, 9);
    rsp_ready = 1'b1;
    drain();

    // Three back-to-back commands: two low select cycles between windows.
    gapArm = 1'b1;
    push(2'd3, 8'h00);
    push(2'd0, 8'hFF);
    push(2'd2, 8'hA5);
    drain();
    gapArm = 1'b0;

    // Fill with the response held: one in flight, four queued.
    rsp_ready = 1'b0;
    push(2'd0, 8'h11);
    push(2'd1, 8'h22);
    push(2'd2, 8'h33);
    push(2'd3, 8'h44);
    push(2'd0, 8'h55);
    @(negedge clk);
    check("full_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_slave = 2'd1; cmd_data = 8'h66;
    repeat (5) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("refused_cmd_ready", {31'b0, cmd_ready}, 32'd0);
`ifdef SPI_CMDQ_DROP_CNT_EN
    check("drop_cnt_5", {24'b0, drop_cnt}, 32'd5);
`endif
    repeat (15) @(posedge clk);
    #1;
    check("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("stall_busy", {31'b0, busy}, 32'd0);
    check("stall_select", {28'b0, spi_select}, 32'd0);
    rsp_ready = 1'b1;
    drain();

    // Six more through wrapped pointers.
    push(2'd2, 8'h01);
    push(2'd3, 8'h02);
    push(2'd0, 8'h03);
    push(2'd1, 8'h04);
    push(2'd2, 8'h80);
    push(2'd3, 8'hC3);
    drain();

    // Long refused offer while full: drop counter saturates.
    rsp_ready = 1'b0;
    push(2'd1, 8'h9E);
    push(2'd2, 8'h7B);
    push(2'd3, 8'hE1);
    push(2'd0, 8'h3D);
    push(2'd1, 8'hB6);
    cmd_valid = 1'b1; cmd_slave = 2'd2; cmd_data = 8'h42;
    repeat (300) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("sat_cmd_ready", {31'b0, cmd_ready}, 32'd0);
`ifdef SPI_CMDQ_DROP_CNT_EN
    check("drop_cnt_sat", {24'b0, drop_cnt}, 32'd255);
`endif
    rsp_ready = 1'b1;
    drain();
    repeat (5) @(posedge clk);
    #1;
    check("end_busy", {31'b0, busy}, 32'd0);
    check("end_win_left", expWin.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_cmd_queue.md
# spi_cmd_queue

Command scheduler sitting directly upstream of the 4-slave `spi` core. It buffers byte-transfer commands (target slave plus master byte) in a small FIFO and drives the core's one-hot `select` and master data-in for exactly one full-byte window per command. At the end of each window it captures the core's master output byte into a single-entry response register, handshaked to the consumer.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries; power of 2, ≥2.
- `XFER_CYCLES`, 8: clock cycles per byte window (one per bit).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command FIFO can accept; `!full && !rst`.
- `cmd_slave`  in  2  target slave index 0..3 (0 = Slave1).
- `cmd_data`  in  8  byte the master shifts out.
- `spi_select`  out  4  one-hot slave select to core; `4'b0000` when not transferring.
- `spi_data_out`  out  8  to core master data-in; held stable for the whole window.
- `spi_data_in`  in  8  from core master data-out; sampled once per window.
- `rsp_valid`  out  1  response byte available.
- `rsp_ready`  in  1  consumer takes response.
- `rsp_data`  out  8  byte received from the slave.
- `rsp_slave`  out  2  slave index the response came from.
- `busy`  out  1  high in XFER or GAP.

## Operation
- Reset values: `cmd_ready`=0 during reset, 1 in the first cycle after; `spi_select`=0, `spi_data_out`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_slave`=0, `busy`=0, FIFO empty, state IDLE, bit counter 0.
- FIFO: push on `cmd_valid && cmd_ready`. Pointers are log2(DEPTH) bits, wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
- When full, push is refused even if a pop occurs the same cycle. Simultaneous push and pop on a non-full, non-empty FIFO keeps occupancy unchanged.
- States:
  - IDLE: if FIFO non-empty and `rsp_valid`=0, pop the head, latch slave/data, clear counter, go to XFER. Otherwise stay.
  - XFER: `spi_select` = `1 << slave`, `spi_data_out` = latched byte. Counter increments each cycle. When counter = XFER_CYCLES-1: sample `spi_data_in` into `rsp_data`, latched slave into `rsp_slave`, set `rsp_valid`, go to GAP.
  - GAP: one cycle, `spi_select`=0, `spi_data_out` holds its value; then IDLE.
- Response: `rsp_valid` clears on `rsp_valid && rsp_ready`. A new transfer never starts while `rsp_valid`=1, so no response is ever overwritten.
- `rsp_valid` in IDLE is the registered value, so a pop in GAP unblocks IDLE on the next cycle.
- Reset mid-transfer: `spi_select` is 0 in the cycle after the reset edge. The in-flight command, queued commands, and any pending response are discarded.
- `cmd_slave` carries no invalid encoding; all 4 values are legal.

## Timing
- Command accepted at edge E0 into an empty FIFO with the response slot free: IDLE pops at E1. `spi_select` is high for cycles E1..E1+XFER_CYCLES (exactly XFER_CYCLES cycles). `rsp_valid` rises at edge E1+XFER_CYCLES.
- Latency from acceptance to `rsp_valid` is XFER_CYCLES+1 edges (9 by default).
- Back-to-back with `rsp_ready`=1: select is low 2 cycles (GAP + IDLE) between windows. Transfer period is XFER_CYCLES+2 (10 cycles).
- With `rsp_ready`=0, the scheduler stalls in IDLE. FIFO keeps accepting until full.
- `spi_select` and `spi_data_out` are registered outputs and glitch-free within a window.

## Configuration
- `SPI_CMDQ_DROP_CNT_EN` defined: adds output port `drop_cnt` (out, 8). It increments by 1 each cycle `cmd_valid`=1 while the FIFO is full, saturates at 255, and resets to 0.
- Macro undefined: the port and counter are absent. Refused commands are simply not accepted, with no record.

## Test plan
- Reset: hold `rst` 3 cycles mid-XFER of slave 2 → next cycle `spi_select`=0, `rsp_valid`=0, `cmd_ready`=1 after release; no response ever appears.
- Single command slave 1 (Slave2), data 0xF0, core echoing 0x0F → `spi_select`=4'b0010 for exactly 8 cycles, `rsp_data`=0x0F, `rsp_slave`=1, `rsp_valid` 9 edges after accept.
- Three commands (slave 3 data 0x00, slave 0 data 0xFF, slave 2 data 0xA5), `rsp_ready`=1 → selects 4'b1000, 4'b0001, 4'b0100 in order, each 8 cycles, 2 low cycles between, 3 responses in order.
- Fill with `rsp_ready`=0: push 5 commands at DEPTH=4 → 1 in flight, 4 queued, `cmd_ready` low. Sixth push refused; `drop_cnt` counts the refused cycles with `SPI_CMDQ_DROP_CNT_EN` defined.
- Release `rsp_ready` after the stall → queued 4 drain in order. Pointer wrap is verified by pushing 6 more and checking data integrity.
- Hold `cmd_valid` high 300 cycles while full with `rsp_ready`=0 (macro defined) → `drop_cnt` saturates at 255.
